// File: rtl/c2h_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c2h_arb_pkg
// Brief    : Shared encodings, default widths and round-robin helper for the
//            C2H stream arbiter.
// Revision : 1.0
// ============================================================================
package c2h_arb_pkg;

    localparam int MAX_SRC        = 8;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_NUM_SRC    = 2;
    localparam int DEF_LEN_WIDTH  = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_XFER = ST_XFER,
        S_DONE = ST_DONE
    } state_t;

    // First requester at or after ptr, wrapping within n sources; ptr < n.
    function automatic logic [MAX_SRC-1:0] rr_pick(
        input logic [MAX_SRC-1:0] req,
        input int                 ptr,
        input int                 n
    );
        logic [MAX_SRC-1:0] g;
        int                 idx;
        g = '0;
        for (int k = 0; k < MAX_SRC; k++) begin
            idx = ptr + k;
            if (idx >= n)
                idx = idx - n;
            if (k < n && g == '0 && req[idx[2:0]])
                g[idx[2:0]] = 1'b1;
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/c2h_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : c2h_rr_picker
// Brief    : Combinational round-robin selector: req + pointer -> one-hot
//            grant and binary index.
// Revision : 1.0
// ============================================================================
module c2h_rr_picker
    import c2h_arb_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [MAX_SRC-1:0] w_pick;

    always_comb begin
        w_pick = rr_pick(MAX_SRC'(req), int'(ptr), NUM_SRC);
        grant  = w_pick[NUM_SRC-1:0];
        valid  = |w_pick;
        idx    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_pick[i])
                idx = IDX_W'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/c2h_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : c2h_stream_arbiter
// Brief    : Packet-level round-robin arbiter muxing NUM_SRC FWFT result FIFOs
//            onto one C2H AXI-Stream. Optional C2H_ARB_STATS_EN adds counters.
// Revision : 1.0
// ============================================================================
module c2h_stream_arbiter
    import c2h_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                            user_clk,
    input  logic                            user_rst,
    input  logic [NUM_SRC-1:0]              src_req,
    input  logic [NUM_SRC*LEN_WIDTH-1:0]    src_len,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_fifo_dout,
    input  logic [NUM_SRC-1:0]              src_fifo_empty,
    output logic [NUM_SRC-1:0]              src_fifo_rd_en,
    output logic [NUM_SRC-1:0]              src_grant,
    output logic [NUM_SRC-1:0]              src_done,
    output logic [DATA_WIDTH-1:0]           m_axis_c2h_tdata,
    output logic [KEEP_WIDTH-1:0]           m_axis_c2h_tkeep,
    output logic                            m_axis_c2h_tvalid,
    output logic                            m_axis_c2h_tlast,
    input  logic                            m_axis_c2h_tready
`ifdef C2H_ARB_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0]           pkt_count,
    output logic [31:0]                     stall_cycles
`endif
);

    localparam int IDX_W = $clog2(NUM_SRC);

    state_t                 r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_sel, w_sel_nxt;
    logic [IDX_W-1:0]       r_ptr, w_ptr_nxt;
    logic [NUM_SRC-1:0]     r_grant, w_grant_nxt;
    logic [LEN_WIDTH-1:0]   r_cnt, w_cnt_nxt;

    logic [NUM_SRC-1:0]     w_pick_grant;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;
    logic [LEN_WIDTH-1:0]   w_pick_len;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_sel_empty;
    logic                   w_beat;

    c2h_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (src_req),
        .ptr     (r_ptr),
        .grant   (w_pick_grant),
        .idx     (w_pick_idx),
        .valid   (w_pick_valid)
    );

    always_comb begin
        w_pick_len  = '0;
        w_sel_data  = '0;
        w_sel_empty = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_pick_idx == IDX_W'(i))
                w_pick_len = src_len[i*LEN_WIDTH +: LEN_WIDTH];
            if (r_sel == IDX_W'(i)) begin
                w_sel_data  = src_fifo_dout[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_empty = src_fifo_empty[i];
            end
        end
    end

    // FWFT head holds until popped, so stream outputs stay stable under backpressure.
    assign m_axis_c2h_tvalid = (r_state == S_XFER) && !w_sel_empty;
    assign m_axis_c2h_tdata  = w_sel_data;
    assign m_axis_c2h_tlast  = (r_state == S_XFER) && (r_cnt == LEN_WIDTH'(1));
    assign m_axis_c2h_tkeep  = '1;
    assign w_beat            = m_axis_c2h_tvalid & m_axis_c2h_tready;
    assign src_fifo_rd_en    = w_beat ? r_grant : '0;
    assign src_grant         = r_grant;
    assign src_done          = (r_state == S_DONE) ? r_grant : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) begin
                    w_sel_nxt   = w_pick_idx;
                    w_grant_nxt = w_pick_grant;
                    w_cnt_nxt   = w_pick_len;
                    w_state_nxt = (w_pick_len == '0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (w_beat) begin
                    w_cnt_nxt = r_cnt - LEN_WIDTH'(1);
                    if (r_cnt == LEN_WIDTH'(1))
                        w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_grant_nxt = '0;
                w_ptr_nxt   = (r_sel == IDX_W'(NUM_SRC-1)) ? '0 : r_sel + IDX_W'(1);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef C2H_ARB_STATS_EN
    logic [31:0] r_stall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_pkt_count
        logic [31:0] r_pkt;
        always_ff @(posedge user_clk or posedge user_rst) begin
            if (user_rst)
                r_pkt <= '0;
            else if (src_done[g])
                r_pkt <= r_pkt + 32'd1;
        end
        assign pkt_count[g*32 +: 32] = r_pkt;
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst)
            r_stall <= '0;
        else if (m_axis_c2h_tvalid && !m_axis_c2h_tready && (r_stall != 32'hFFFF_FFFF))
            r_stall <= r_stall + 32'd1;
    end

    assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_c2h_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_c2h_stream_arbiter
// Brief    : Directed self-checking bench for c2h_stream_arbiter (2 sources).
// Revision : 1.0
// ============================================================================
module tb_c2h_stream_arbiter;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     req;
    logic [63:0]    len;
    logic [255:0]   dout;
    logic [1:0]     empty;
    logic [1:0]     rd_en;
    logic [1:0]     grant;
    logic [1:0]     done;
    logic [127:0]   tdata;
    logic [15:0]    tkeep;
    logic           tvalid;
    logic           tlast;
    logic           tready;

    always #5 clk = ~clk;

    c2h_stream_arbiter dut (
        .user_clk          (clk),
        .user_rst          (rst),
        .src_req           (req),
        .src_len           (len),
        .src_fifo_dout     (dout),
        .src_fifo_empty    (empty),
        .src_fifo_rd_en    (rd_en),
        .src_grant         (grant),
        .src_done          (done),
        .m_axis_c2h_tdata  (tdata),
        .m_axis_c2h_tkeep  (tkeep),
        .m_axis_c2h_tvalid (tvalid),
        .m_axis_c2h_tlast  (tlast),
        .m_axis_c2h_tready (tready)
    );

    // FWFT FIFO models: head is mem[rd], empty when rd == wr.
    logic [127:0] mem0 [0:31];
    logic [127:0] mem1 [0:31];
    logic [4:0]   rdp0 = 5'd0;
    logic [4:0]   rdp1 = 5'd0;
    logic [4:0]   wrp0 = 5'd0;
    logic [4:0]   wrp1 = 5'd0;

    assign empty[0]       = (rdp0 == wrp0);
    assign empty[1]       = (rdp1 == wrp1);
    assign dout[127:0]    = mem0[rdp0];
    assign dout[255:128]  = mem1[rdp1];

    always @(posedge clk) begin
        if (rd_en[0]) rdp0 <= rdp0 + 5'd1;
        if (rd_en[1]) rdp1 <= rdp1 + 5'd1;
    end

    // Beat capture and sideband sanity.
    int           cap_n = 0;
    logic [127:0] cap_d [0:63];
    logic         cap_l [0:63];
    int           viol  = 0;

    always @(posedge clk) begin
        if (tvalid && tready && cap_n < 64) begin
            cap_d[cap_n] <= tdata;
            cap_l[cap_n] <= tlast;
            cap_n        <= cap_n + 1;
        end
        if (((rd_en & ~grant) != 2'b00) || ((done & ~grant) != 2'b00) ||
            ((rd_en != 2'b00) && !(tvalid && tready)))
            viol <= viol + 1;
    end

    int n_chk = 0;
    int n_err = 0;
    int b;
    int p0;
    logic         stall_prev;
    logic [127:0] prev_d;
    logic         prev_l;

    function automatic logic [127:0] mk(input int s, input int p, input int k);
        return {32'(s), 32'(p), 32'hDEAD_BEEF, 32'(k)};
    endfunction

    task automatic load(input int s, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            if (s == 0) begin
                mem0[wrp0] = mk(s, p, k);
                wrp0       = wrp0 + 5'd1;
            end else begin
                mem1[wrp1] = mk(s, p, k);
                wrp1       = wrp1 + 5'd1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int s, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done[s]) seen = 1'b1;
        end
        chk(tag, seen, 1'b1);
    endtask

    initial begin
        req    = 2'b00;
        len    = '0;
        tready = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_grant",  grant,  2'b00);
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tlast",  tlast,  1'b0);
        chk("rst_rd_en",  rd_en,  2'b00);
        chk("rst_done",   done,   2'b00);
        chk("rst_tkeep",  tkeep,  16'hFFFF);
        rst = 1'b0;

        // Single source, 4 beats, cycle by cycle.
        load(0, 1, 4);
        len[31:0] = 32'd4;
        req       = 2'b01;
        @(negedge clk);
        chk("t1_grant", grant, 2'b01);
        chk("t1_valid", tvalid, 1'b1);
        chk("t1_d0",    tdata, mk(0, 1, 0));
        chk("t1_last0", tlast, 1'b0);
        chk("t1_rd_en", rd_en, 2'b01);
        @(negedge clk);
        chk("t1_d1",    tdata, mk(0, 1, 1));
        @(negedge clk);
        chk("t1_d2",    tdata, mk(0, 1, 2));
        chk("t1_last2", tlast, 1'b0);
        @(negedge clk);
        chk("t1_d3",    tdata, mk(0, 1, 3));
        chk("t1_last3", tlast, 1'b1);
        @(negedge clk);
        chk("t1_done",   done,   2'b01);
        chk("t1_nvalid", tvalid, 1'b0);
        req = 2'b00;
        @(negedge clk);
        chk("t1_done_clr",  done,  2'b00);
        chk("t1_grant_clr", grant, 2'b00);
        chk("t1_pops",      rdp0,  5'd4);

        // Zero-length packet on source 1.
        b          = cap_n;
        len[63:32] = 32'd0;
        req        = 2'b10;
        @(negedge clk);
        chk("z_grant", grant,  2'b10);
        chk("z_done",  done,   2'b10);
        chk("z_valid", tvalid, 1'b0);
        req = 2'b00;
        @(negedge clk);
        chk("z_done_clr", done, 2'b00);
        chk("z_no_beats", cap_n - b, 0);

        // Simultaneous requests; source 0 re-requests and must yield to source 1.
        b = cap_n;
        load(0, 2, 3);
        load(1, 2, 2);
        len = {32'd2, 32'd3};
        req = 2'b11;
        @(negedge clk);
        chk("rr_first", grant, 2'b01);
        wait_done(0, "t2_done0");
        load(0, 3, 1);
        len[31:0] = 32'd1;
        @(negedge clk);
        chk("rr_idle_gap", grant, 2'b00);
        @(negedge clk);
        chk("rr_second", grant, 2'b10);
        wait_done(1, "t2_done1");
        req[1] = 1'b0;
        wait_done(0, "t2_done0b");
        req[0] = 1'b0;
        @(negedge clk);
        chk("t2_nbeats", cap_n - b, 6);
        chk("t2_d0", cap_d[b+0], mk(0, 2, 0));
        chk("t2_d2", cap_d[b+2], mk(0, 2, 2));
        chk("t2_l2", cap_l[b+2], 1'b1);
        chk("t2_d3", cap_d[b+3], mk(1, 2, 0));
        chk("t2_l3", cap_l[b+3], 1'b0);
        chk("t2_d4", cap_d[b+4], mk(1, 2, 1));
        chk("t2_l4", cap_l[b+4], 1'b1);
        chk("t2_d5", cap_d[b+5], mk(0, 3, 0));
        chk("t2_l5", cap_l[b+5], 1'b1);

        // Backpressure: tready pattern 1,0,0 repeating.
        b  = cap_n;
        p0 = int'(rdp0);
        load(0, 4, 5);
        len[31:0]  = 32'd5;
        req        = 2'b01;
        stall_prev = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        for (int i = 0; i < 100 && !done[0]; i++) begin
            @(negedge clk);
            if (!done[0]) begin
                if (stall_prev) begin
                    chk("bp_valid_hold", tvalid, 1'b1);
                    chk("bp_data_hold",  tdata,  prev_d);
                    chk("bp_last_hold",  tlast,  prev_l);
                end
                tready     = (i % 3 == 0);
                stall_prev = tvalid && !tready;
                prev_d     = tdata;
                prev_l     = tlast;
            end
        end
        chk("bp_done", done[0], 1'b1);
        req    = 2'b00;
        tready = 1'b1;
        @(negedge clk);
        chk("bp_nbeats", cap_n - b, 5);
        chk("bp_pops",   int'(rdp0) - p0, 5);
        for (int k = 0; k < 5; k++) begin
            chk("bp_data", cap_d[b+k], mk(0, 4, k));
            chk("bp_last", cap_l[b+k], (k == 4));
        end

        // FIFO underrun after the first beat.
        b = cap_n;
        load(0, 5, 1);
        len[31:0] = 32'd3;
        req       = 2'b01;
        @(negedge clk);
        chk("un_v0", tvalid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("un_stall_valid", tvalid, 1'b0);
            chk("un_stall_rd_en", rd_en,  2'b00);
        end
        load(0, 5, 1);
        mem0[wrp0 - 5'd1] = mk(0, 5, 1);
        #1;
        chk("un_v1",    tvalid, 1'b1);
        chk("un_last1", tlast,  1'b0);
        @(negedge clk);
        load(0, 5, 1);
        mem0[wrp0 - 5'd1] = mk(0, 5, 2);
        #1;
        chk("un_last2", tlast, 1'b1);
        wait_done(0, "un_done");
        req = 2'b00;
        @(negedge clk);
        chk("un_nbeats", cap_n - b, 3);
        chk("un_d1",     cap_d[b+1], mk(0, 5, 1));
        chk("un_d2",     cap_d[b+2], mk(0, 5, 2));
        chk("un_l2",     cap_l[b+2], 1'b1);

        // Asynchronous reset after beat 2 of 6.
        b = cap_n;
        load(0, 6, 6);
        len[31:0] = 32'd6;
        req       = 2'b01;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("ar_beats",  cap_n - b, 2);
        chk("ar_grant",  grant,  2'b00);
        chk("ar_tvalid", tvalid, 1'b0);
        chk("ar_tlast",  tlast,  1'b0);
        chk("ar_rd_en",  rd_en,  2'b00);
        chk("ar_done",   done,   2'b00);
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        b = cap_n;
        load(1, 7, 2);
        len[63:32] = 32'd2;
        req        = 2'b10;
        @(negedge clk);
        chk("fr_grant", grant, 2'b10);
        wait_done(1, "fr_done");
        req = 2'b00;
        @(negedge clk);
        chk("fr_nbeats", cap_n - b, 2);
        chk("fr_d0",     cap_d[b+0], mk(1, 7, 0));
        chk("fr_l0",     cap_l[b+0], 1'b0);
        chk("fr_d1",     cap_d[b+1], mk(1, 7, 1));
        chk("fr_l1",     cap_l[b+1], 1'b1);

        chk("sideband_violations", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
